// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared constants and types for the sync_fifo family.
//   WIDTH_DEF / DEPTH_DEF : default data width and entry count
//   ptr_width()           : pointer width for a given power-of-two depth
//   count_t               : occupancy/level type for the default depth
package sync_fifo_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 8;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
    typedef logic [ptr_width(DEPTH_DEF):0] count_t;

endpackage

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
// Combinational status flags derived from an occupancy count and two
// programmable thresholds. Kept free of pointer/memory state so that a
// dual-clock variant can reuse it on a synchronised count.
// Ports:
//   count        in   current occupancy, 0..DEPTH
//   ae_level     in   almost-empty threshold
//   af_level     in   almost-full threshold
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= af_level
//   almost_empty out  count <= ae_level
//   half_full    out  count >= DEPTH/2
module sync_fifo_flags #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] ae_level,
    input  logic [CNT_W-1:0] af_level,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             half_full
);

    always_comb begin
        full         = (count == CNT_W'(DEPTH));
        empty        = (count == '0);
        almost_full  = (count >= af_level);
        almost_empty = (count <= ae_level);
        half_full    = (count >= CNT_W'(DEPTH / 2));
    end

endmodule

// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged
// Single-clock FIFO with registered read data, occupancy count, threshold
// status flags and sticky overflow/underflow flags.
// Optional feature: define SYNC_FIFO_HWM_EN to add the hwm (peak occupancy)
// register and port.
// Ports:
//   clk, rst (async, active-low)
//   Data_in, write_to_stack, read_from_stack   write/read requests
//   ae_level, af_level                         flag thresholds
//   clr_err                                    clears overflow/underflow (and hwm)
//   Data_out, data_valid                       read data, valid for one cycle
//   count, stack_* flags                       occupancy and status
//   overflow, underflow                        sticky error flags
//   hwm                                        peak occupancy (SYNC_FIFO_HWM_EN)
module sync_fifo_flagged
    import sync_fifo_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             write_to_stack,
    input  logic             read_from_stack,
    input  logic [CNT_W-1:0] ae_level,
    input  logic [CNT_W-1:0] af_level,
    input  logic             clr_err,
`ifdef SYNC_FIFO_HWM_EN
    output logic [CNT_W-1:0] hwm,
`endif
    output logic [WIDTH-1:0] Data_out,
    output logic             data_valid,
    output logic [CNT_W-1:0] count,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_almost_full,
    output logic             stack_almost_empty,
    output logic             stack_half_full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_ok, wr_ok;

    sync_fifo_flags #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_flags (
        .count        (count_q),
        .ae_level     (ae_level),
        .af_level     (af_level),
        .full         (stack_full),
        .empty        (stack_empty),
        .almost_full  (stack_almost_full),
        .almost_empty (stack_almost_empty),
        .half_full    (stack_half_full)
    );

    // A full FIFO can still take a write when a read frees a slot in the same cycle.
    assign rd_ok = read_from_stack && !stack_empty;
    assign wr_ok = write_to_stack && (!stack_full || rd_ok);

    always_comb begin
        wr_ptr_d     = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        data_out_d   = rd_ok ? mem_q[rd_ptr_q] : data_out_q;
        data_valid_d = rd_ok;

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // New errors take priority over clr_err in the same cycle.
        if (write_to_stack && !wr_ok) overflow_d = 1'b1;
        else if (clr_err)             overflow_d = 1'b0;
        else                          overflow_d = overflow_q;

        if (read_from_stack && !rd_ok) underflow_d = 1'b1;
        else if (clr_err)              underflow_d = 1'b0;
        else                           underflow_d = underflow_q;
    end

    // Storage is not reset; only the pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= Data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_HWM_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;

    // A new peak in the same cycle overrides clr_err.
    always_comb begin
        if (count_d > hwm_q) hwm_d = count_d;
        else if (clr_err)    hwm_d = '0;
        else                 hwm_d = hwm_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hwm_q <= '0;
        else      hwm_q <= hwm_d;
    end

    assign hwm = hwm_q;
`endif

    assign Data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
